// File: rtl/key_note_encoder_pkg.sv
// -----------------------------------------------------------------------------
// key_note_encoder_pkg
// Purpose : Shared constants and helpers for the piano key input path. The
//           4-bit note codes are also used by the LED display and the tone
//           generator, so they live here and nowhere else.
// Contents: NOTE_* codes, note_code_t, NUM_KEYS, encode_keys() priority
//           encoder (highest pitch wins).
// -----------------------------------------------------------------------------
package key_note_encoder_pkg;

    localparam int NUM_KEYS = 8;

    typedef logic [3:0] note_code_t;

    localparam note_code_t NOTE_C5   = 4'h0;
    localparam note_code_t NOTE_B    = 4'h1;
    localparam note_code_t NOTE_A    = 4'h2;
    localparam note_code_t NOTE_G    = 4'h3;
    localparam note_code_t NOTE_F    = 4'h4;
    localparam note_code_t NOTE_E    = 4'h5;
    localparam note_code_t NOTE_D    = 4'h6;
    localparam note_code_t NOTE_C4   = 4'h7;
    localparam note_code_t NOTE_NONE = 4'h8;

    // Key bit 7 is C5 (highest pitch) and takes priority over everything
    // below it; bit 0 is C4. No key held gives NOTE_NONE.
    function automatic note_code_t encode_keys(input logic [NUM_KEYS-1:0] keys);
        note_code_t code;
        if (keys[7])      code = NOTE_C5;
        else if (keys[6]) code = NOTE_B;
        else if (keys[5]) code = NOTE_A;
        else if (keys[4]) code = NOTE_G;
        else if (keys[3]) code = NOTE_F;
        else if (keys[2]) code = NOTE_E;
        else if (keys[1]) code = NOTE_D;
        else if (keys[0]) code = NOTE_C4;
        else              code = NOTE_NONE;
        return code;
    endfunction

endpackage

// File: rtl/key_note_encoder_if.sv
// -----------------------------------------------------------------------------
// key_note_encoder_if
// Purpose : Bundles the key input and note output signals of the encoder.
// Signals : key_raw     - raw key levels, 1 = pressed (bit 0 = C4, bit 7 = C5)
//           key_db      - debounced key levels
//           note        - encoded note code (NOTE_* in the package)
//           note_change - one-cycle pulse on the first cycle of a new note
// Modports: master - drives key_raw, observes outputs (keyboard side / bench)
//           slave  - the encoder itself
// -----------------------------------------------------------------------------
interface key_note_encoder_if;
    import key_note_encoder_pkg::*;

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_db;
    note_code_t          note;
    logic                note_change;

    modport master (
        output key_raw,
        input  key_db,
        input  note,
        input  note_change
    );

    modport slave (
        input  key_raw,
        output key_db,
        output note,
        output note_change
    );

endinterface

// File: rtl/key_note_encoder_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Purpose : Single-bit two-flop synchroniser followed by a stability counter.
//           The debounced level only follows the synchronised input after it
//           has differed from the current level for DEBOUNCE_CYCLES
//           consecutive clocks; any return to the current level restarts
//           the count.
// Ports   : clk       - system clock
//           rst_n     - synchronous active-low reset
//           i_key_raw - asynchronous key level
//           o_key_db  - debounced key level (registered)
// -----------------------------------------------------------------------------
module key_debounce
    import key_note_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_raw,
    output logic o_key_db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_key_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // This edge is the DEBOUNCE_CYCLES-th consecutive one with
                // r_s2 different from r_db, so the new level is accepted.
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_key_db = r_db;

endmodule

// File: rtl/key_note_encoder.sv
// -----------------------------------------------------------------------------
// key_note_encoder
// Purpose : Synchronises and debounces the 8 piano keys, priority-encodes the
//           held keys into the shared 4-bit note code and pulses note_change
//           for one cycle whenever the registered note takes a new value.
// Ports   : clk   - system clock, all state on the rising edge
//           rst_n - synchronous active-low reset
//           bus   - key_note_encoder_if.slave:
//                     key_raw (in), key_db/note/note_change (out)
// Params  : DEBOUNCE_CYCLES - stable cycles needed to change a key level
//           CNT_W           - width of each per-key debounce counter
// -----------------------------------------------------------------------------
module key_note_encoder
    import key_note_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    key_note_encoder_if.slave   bus
);

    logic [NUM_KEYS-1:0] w_key_db;
    note_code_t          w_note_enc;
    note_code_t          r_note;
    logic                r_note_change;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_key_debounce (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_key_raw (bus.key_raw[gi]),
                .o_key_db  (w_key_db[gi])
            );
        end
    endgenerate

    assign w_note_enc = encode_keys(w_key_db);

    // The pulse compares the value being loaded against the value held, so
    // a lower-priority key changing under a held higher key gives no pulse,
    // and several keys flipping together give at most one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_note        <= NOTE_NONE;
            r_note_change <= 1'b0;
        end else begin
            r_note        <= w_note_enc;
            r_note_change <= (w_note_enc != r_note);
        end
    end

    assign bus.key_db      = w_key_db;
    assign bus.note        = r_note;
    assign bus.note_change = r_note_change;

endmodule

// File: tb/tb_key_note_encoder.sv
// -----------------------------------------------------------------------------
// tb_key_note_encoder
// Directed scenarios with hand-computed expectations, then randomized key
// activity with occasional resets. A reference model working on the raw
// sample history (a key flips once its last DEBOUNCE_CYCLES synchronised
// samples all differ from its debounced level) is compared against the DUT
// on every cycle.
// -----------------------------------------------------------------------------
module tb_key_note_encoder;

    localparam int DBC  = 4;
    localparam int CW   = 3;
    localparam int HIST = 16;

    logic clk = 1'b0;
    logic rst_n;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    key_note_encoder_if kif ();

    key_note_encoder #(
        .DEBOUNCE_CYCLES (DBC),
        .CNT_W           (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] hist [HIST];   // hist[0] = raw sampled at the previous edge
    logic [7:0] m_db     = 8'h00;
    logic [3:0] m_note   = 4'h8;
    logic       m_chg    = 1'b0;
    logic [3:0] m_next;
    bit         all_diff;

    function automatic logic [3:0] model_encode(input logic [7:0] v);
        logic [3:0] code;
        bit found;
        code  = 4'd8;
        found = 1'b0;
        for (int b = 7; b >= 0; b--) begin
            if (!found && v[b]) begin
                code  = 4'(7 - b);
                found = 1'b1;
            end
        end
        return code;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST; i++) hist[i] = 8'h00;
            m_db   = 8'h00;
            m_note = 4'h8;
            m_chg  = 1'b0;
        end else begin
            m_next = model_encode(m_db);
            m_chg  = (m_next != m_note);
            m_note = m_next;
            // Synchronised input at this edge is the raw value from two edges
            // ago, so the window is hist[1..DBC].
            for (int k = 0; k < 8; k++) begin
                all_diff = 1'b1;
                for (int i = 1; i <= DBC; i++)
                    if (hist[i][k] == m_db[k]) all_diff = 1'b0;
                if (all_diff) m_db[k] = ~m_db[k];
            end
            for (int i = HIST - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = kif.key_raw;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (kif.key_db !== m_db) begin
                failures++;
                $display("FAIL model_key_db t=%0t: got %02h expected %02h", $time, kif.key_db, m_db);
            end
            checks++;
            if (kif.note !== m_note) begin
                failures++;
                $display("FAIL model_note t=%0t: got %0d expected %0d", $time, kif.note, m_note);
            end
            checks++;
            if (kif.note_change !== m_chg) begin
                failures++;
                $display("FAIL model_note_change t=%0t: got %0b expected %0b", $time, kif.note_change, m_chg);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] rnd_keys;

    initial begin
        rst_n       = 1'b0;
        kif.key_raw = 8'hFF;

        // Reset held for two edges with every key pressed
        $display("reset: rst_n=0 key_raw=FF for 2 cycles");
        step();
        chk_en = 1'b1;
        chk("reset1_note", {4'h0, kif.note}, 8'h08);
        chk("reset1_chg", {7'h0, kif.note_change}, 8'h00);
        chk("reset1_key_db", kif.key_db, 8'h00);
        step();
        chk("reset2_note", {4'h0, kif.note}, 8'h08);
        chk("reset2_key_db", kif.key_db, 8'h00);
        rst_n       = 1'b1;
        kif.key_raw = 8'h00;
        steps(8);

        // Single key C4: key_db at E0+5, note/pulse at E0+6
        $display("press C4: key_raw=01");
        kif.key_raw = 8'h01;
        steps(5);
        chk("c4_key_db_E4", kif.key_db, 8'h00);
        step();
        chk("c4_key_db_E5", kif.key_db, 8'h01);
        chk("c4_note_E5", {4'h0, kif.note}, 8'h08);
        step();
        chk("c4_note_E6", {4'h0, kif.note}, 8'h07);
        chk("c4_chg_E6", {7'h0, kif.note_change}, 8'h01);
        step();
        chk("c4_chg_E7", {7'h0, kif.note_change}, 8'h00);

        // Short pulse and chatter on key 3 must be filtered
        $display("glitch: key_raw[3] high for 3 cycles");
        kif.key_raw = 8'h09;
        steps(3);
        kif.key_raw = 8'h01;
        steps(10);
        chk("glitch_key_db", kif.key_db, 8'h01);
        $display("chatter: key_raw[3] toggling every 2 cycles");
        for (int i = 0; i < 10; i++) begin
            kif.key_raw = (i % 2 == 0) ? 8'h09 : 8'h01;
            steps(2);
        end
        kif.key_raw = 8'h01;
        steps(10);
        chk("chatter_key_db", kif.key_db, 8'h01);
        chk("chatter_note", {4'h0, kif.note}, 8'h07);

        // Priority: C5 and C4 held gives C5
        $display("press C5 with C4: key_raw=81");
        kif.key_raw = 8'h81;
        steps(12);
        chk("c5c4_note", {4'h0, kif.note}, 8'h00);
        $display("release C5: key_raw=01");
        kif.key_raw = 8'h01;
        steps(6);
        chk("relc5_chg_E5", {7'h0, kif.note_change}, 8'h00);
        chk("relc5_note_E5", {4'h0, kif.note}, 8'h00);
        step();
        chk("relc5_note_E6", {4'h0, kif.note}, 8'h07);
        chk("relc5_chg_E6", {7'h0, kif.note_change}, 8'h01);
        $display("press E with C4: key_raw=05");
        kif.key_raw = 8'h05;
        steps(7);
        chk("e_note_E6", {4'h0, kif.note}, 8'h05);
        chk("e_chg_E6", {7'h0, kif.note_change}, 8'h01);
        step();
        chk("e_chg_E7", {7'h0, kif.note_change}, 8'h00);
        kif.key_raw = 8'h00;
        steps(12);
        chk("allup_note", {4'h0, kif.note}, 8'h08);

        // Reset mid-count discards the partial count
        $display("reset mid-count: key_raw=20");
        kif.key_raw = 8'h20;
        steps(3);
        rst_n = 1'b0;
        step();
        chk("midrst_note", {4'h0, kif.note}, 8'h08);
        chk("midrst_key_db", kif.key_db, 8'h00);
        rst_n = 1'b1;
        steps(6);
        chk("midrst_note_R5", {4'h0, kif.note}, 8'h08);
        chk("midrst_chg_R5", {7'h0, kif.note_change}, 8'h00);
        step();
        chk("midrst_note_R6", {4'h0, kif.note}, 8'h02);
        chk("midrst_chg_R6", {7'h0, kif.note_change}, 8'h01);

        // Release all from note A
        $display("release all: key_raw=00");
        kif.key_raw = 8'h00;
        steps(6);
        chk("rel_chg_E5", {7'h0, kif.note_change}, 8'h00);
        step();
        chk("rel_note_E6", {4'h0, kif.note}, 8'h08);
        chk("rel_chg_E6", {7'h0, kif.note_change}, 8'h01);

        // Randomized key activity with occasional resets
        $display("random: 4000 cycles");
        rnd_keys = 8'h00;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0)
                rnd_keys[$urandom_range(0, 7)] = ~rnd_keys[$urandom_range(0, 7)];
            if ($urandom_range(0, 19) == 0)
                rnd_keys = 8'($urandom());
            kif.key_raw = rnd_keys;
            rst_n = ($urandom_range(0, 599) != 0);
            step();
        end
        rst_n = 1'b1;
        steps(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_note_encoder.md
Name: key_note_encoder

Overview:
- Input-side counterpart of the note-to-LED display path.
- Takes the 8 raw piano key inputs (switches/buttons) and synchronises and debounces each one.
- Priority-encodes the held keys into the shared 4-bit note code used by the LED and tone logic.
- Emits a one-cycle strobe whenever the encoded note changes; feeds both the LED display and the tone generator.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required before a key's debounced level changes (5 ms at 100 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 20, width of each per-key debounce counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- key_raw  input  8  asynchronous key levels, 1 = pressed; bit 0 = C4 ... bit 7 = C5.
- key_db  output  8  debounced key levels, registered.
- note  output  4  encoded note: 0=C5, 1=B, 2=A, 3=G, 4=F, 5=E, 6=D, 7=C4, 8=none; registered.
- note_change  output  1  one-cycle pulse, high in the first cycle in which note holds a new value.

Behaviour:
Reset (rst_n low at a clk edge):
- All sync flops, counters and key_db go to 0.
- note goes to 8 (none); note_change goes to 0.
- Applies mid-count: any partial count is discarded.

Synchroniser:
- 2 flops per bit (s1, s2); s2 feeds the debouncer.

Per-key debouncer, evaluated each edge:
- if s2 == db: cnt <= 0.
- else if cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
- else: cnt <= cnt+1.
- A pulse or chatter shorter than DEBOUNCE_CYCLES stable cycles at s2 never changes db.
- Counting restarts whenever s2 returns to db.

Encoder (registered, one cycle after key_db):
- Lowest code wins, i.e. highest pitch: key_db[7] gives 0, else key_db[6] gives 1, ..., else key_db[0] gives 7, else 8.
- Codes 9..15 are never produced.

note_change:
- Registered: high for exactly one cycle on the edge where note is loaded with a value different from its previous value.
- Not asserted by reset.
- Not asserted when a lower-priority key changes while a higher key is held and the note is unchanged.

Latency:
- key_raw stable from sampling edge E0 gives a key_db update at edge E0+DEBOUNCE_CYCLES+1.
- note and note_change update at edge E0+DEBOUNCE_CYCLES+2.

Simultaneous events:
- Independent keys debounce independently.
- Several keys flipping db on the same edge produce one encoded result and at most one pulse.

Decomposition:
- Shared constants in the project parameters include file: NOTE_C5=4'h0, NOTE_B=4'h1, NOTE_A=4'h2, NOTE_G=4'h3, NOTE_F=4'h4, NOTE_E=4'h5, NOTE_D=4'h6, NOTE_C4=4'h7, NOTE_NONE=4'h8.
- The encoder and the LED display both use these constants.
- One sub-module, key_debounce: a single-bit synchroniser plus counter with parameters DEBOUNCE_CYCLES and CNT_W; instantiated 8 times via generate.
- The priority encoder and change detect stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Hold rst_n=0 for 2 cycles, key_raw=8'hFF -> note=8, note_change=0, key_db=0 throughout reset.
- key_raw=8'h01 from edge E0 and held -> key_db=8'h01 at E0+5; note=7 with note_change=1 at E0+6 only; note_change=0 at E0+7.
- key_raw[3] high for 3 cycles then low, plus a separate case toggling every 2 cycles for 20 cycles -> key_db and note never change, no pulse.
- Bits 0 and 7 held -> note=0. Then release bit 7 -> note=7 with one pulse at release+6. Then press bit 2 while bit 0 is held -> note=5 with one pulse.
- key_raw[5] high for 3 cycles, then rst_n=0 for one edge while the key stays high -> counter cleared, note=8. After reset releases at edge R -> note=2 with pulse at R+6, not earlier.
- From note=2, set key_raw=0 -> note=8 with one note_change pulse at E0+6.
